// File: rtl/ram_store_unit.sv
// ============================================================================
//  Module   : ram_store_unit
//  Brief    : rv32i store unit (SB/SH/SW). Steers store data into byte lanes
//             and writes a word-wide data RAM. Without RAM byte enables,
//             sub-word stores run as read-modify-write.
//  Config   : RAM_STORE_BYTE_EN_EN - RAM honours mem_be; B/H stores write
//             directly with replicated data and lane enables.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_store_pkg;
   typedef enum logic [1:0] {
      RAM_MASK_B = 2'b00,
      RAM_MASK_H = 2'b01,
      RAM_MASK_W = 2'b10
   } ram_mask_e;
endpackage

module ram_store_unit
   import ram_store_pkg::*;
#(
   parameter int ADDR_W     = 30,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_data,
   input  ram_mask_e         req_mask,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   input  logic [31:0]       mem_rdata,
   output logic              mem_we,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WAIT = 3'd2,
      S_WR   = 3'd3,
      S_ERR  = 3'd4
   } state_e;

   // Last WAIT count value: read data is valid in that cycle.
   localparam logic [1:0] C_LAT_LAST = 2'(RD_LATENCY - 1);

   state_e              r_state, w_state_nx;
   logic [1:0]          r_cnt, w_cnt_nx;
   logic [1:0]          r_lane, w_lane_nx;
   logic                r_is_b, w_is_b_nx;
   logic                r_is_h, w_is_h_nx;
   logic [31:0]         r_data, w_data_nx;
   logic [ADDR_W-1:0]   r_mem_addr, w_addr_nx;
   logic                r_mem_re, w_re_nx;
   logic                r_mem_we, w_we_nx;
   logic [31:0]         r_mem_wdata, w_wdata_nx;
   logic [3:0]          r_mem_be, w_be_nx;
   logic                r_done, w_done_nx;
   logic                r_err, w_err_nx;

   logic                w_req_b, w_req_h, w_misal;
   logic [31:0]         w_merged;

   assign req_ready = (r_state == S_IDLE) & ~rst;
   assign mem_addr  = r_mem_addr;
   assign mem_re    = r_mem_re;
   assign mem_we    = r_mem_we;
   assign mem_wdata = r_mem_wdata;
   assign mem_be    = r_mem_be;
   assign done      = r_done;
   assign err       = r_err;

   // Unknown mask encodings fall through to word stores.
   assign w_req_b = (req_mask == RAM_MASK_B);
   assign w_req_h = (req_mask == RAM_MASK_H);
   assign w_misal = (w_req_h & req_addr[0]) |
                    (~w_req_b & ~w_req_h & (req_addr[1:0] != 2'b00));

   // Merge the captured store bytes over the word read back from RAM.
   always_comb begin
      w_merged = mem_rdata;
      if (r_is_b) begin
         w_merged[8*r_lane +: 8] = r_data[7:0];
      end else if (r_is_h) begin
         w_merged[16*r_lane[1] +: 16] = r_data[15:0];
      end
   end

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_lane_nx  = r_lane;
      w_is_b_nx  = r_is_b;
      w_is_h_nx  = r_is_h;
      w_data_nx  = r_data;
      w_addr_nx  = r_mem_addr;
      w_re_nx    = 1'b0;
      w_we_nx    = 1'b0;
      w_wdata_nx = r_mem_wdata;
      w_be_nx    = r_mem_be;
      w_done_nx  = 1'b0;
      w_err_nx   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               w_lane_nx = req_addr[1:0];
               w_is_b_nx = w_req_b;
               w_is_h_nx = w_req_h;
               w_data_nx = req_data;
               if (w_misal) begin
                  w_state_nx = S_ERR;
                  w_err_nx   = 1'b1;
               end else begin
                  w_addr_nx = req_addr[ADDR_W+1:2];
                  if (!w_req_b && !w_req_h) begin
                     w_state_nx = S_WR;
                     w_we_nx    = 1'b1;
                     w_done_nx  = 1'b1;
                     w_wdata_nx = req_data;
                     w_be_nx    = 4'hF;
                  end else begin
`ifdef RAM_STORE_BYTE_EN_EN
                     w_state_nx = S_WR;
                     w_we_nx    = 1'b1;
                     w_done_nx  = 1'b1;
                     if (w_req_b) begin
                        w_wdata_nx = {4{req_data[7:0]}};
                        w_be_nx    = 4'b0001 << req_addr[1:0];
                     end else begin
                        w_wdata_nx = {2{req_data[15:0]}};
                        w_be_nx    = 4'b0011 << {req_addr[1], 1'b0};
                     end
`else
                     w_state_nx = S_RD;
                     w_re_nx    = 1'b1;
`endif
                  end
               end
            end
         end
         S_RD: begin
            w_state_nx = S_WAIT;
            w_cnt_nx   = 2'd0;
         end
         S_WAIT: begin
            if (r_cnt == C_LAT_LAST) begin
               w_state_nx = S_WR;
               w_we_nx    = 1'b1;
               w_done_nx  = 1'b1;
               w_wdata_nx = w_merged;
               w_be_nx    = 4'hF;
            end else begin
               w_cnt_nx = r_cnt + 2'd1;
            end
         end
         S_WR:    w_state_nx = S_IDLE;
         S_ERR:   w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   // State and output registers; reset drops any in-flight store.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 2'd0;
         r_lane      <= 2'd0;
         r_is_b      <= 1'b0;
         r_is_h      <= 1'b0;
         r_data      <= 32'd0;
         r_mem_addr  <= '0;
         r_mem_re    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_wdata <= 32'd0;
         r_mem_be    <= 4'd0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_cnt       <= w_cnt_nx;
         r_lane      <= w_lane_nx;
         r_is_b      <= w_is_b_nx;
         r_is_h      <= w_is_h_nx;
         r_data      <= w_data_nx;
         r_mem_addr  <= w_addr_nx;
         r_mem_re    <= w_re_nx;
         r_mem_we    <= w_we_nx;
         r_mem_wdata <= w_wdata_nx;
         r_mem_be    <= w_be_nx;
         r_done      <= w_done_nx;
         r_err       <= w_err_nx;
      end
   end

endmodule

`default_nettype wire
